mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter_starve_ctr.sv | 32 +++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// response-owner encoding, default widths and the starvation counter width helper.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DM   = 2'd2
    } rsp_owner_e;

    // Counter must hold max_cnt; never narrower than 3 bits.
    function automatic int starve_cnt_w(input int max_cnt);
        int w;
        w = 3;
        while ((1 << w) <= max_cnt) w++;
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core ports, the arbiter and the SRAM macro.
// slave: arbiter view. master: core + SRAM view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_port_arbiter_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_port_arbiter_pkg::DATA_W_DEF
);
    localparam int NB = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic [NB-1:0]     dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              sram_ce;
    logic [NB-1:0]     sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output sram_ce, sram_we, sram_addr, sram_wdata,
        input  sram_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  sram_ce, sram_we, sram_addr, sram_wdata,
        output sram_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Fetch starvation counter: counts consecutive denied fetch cycles and
// forces one fetch grant once the count reaches STARVE_MAX.
module arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic fetch_force
);
    localparam int               CNT_W   = starve_cnt_w(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;

    // Count denied fetch cycles, saturating at CNT_MAX; any grant or dropped request clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!if_req || if_gnt) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign fetch_force = if_req && (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified I/D memory arbiter: one SRAM access per cycle, data port has
// priority over fetch, one-cycle read data routed back to its owner.
// Optional fetch fairness is enabled with `define MEM_ARB_FAIR_EN.
//
// Response owner register:
//   state    | meaning
//   RSP_NONE | no read issued last cycle (idle, write, or reset)
//   RSP_IF   | last cycle issued a fetch read; sram_rdata belongs to fetch
//   RSP_DM   | last cycle issued a data read; sram_rdata belongs to data port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int NB = DATA_W / 8;

    rsp_owner_e rsp_q;
    rsp_owner_e rsp_nxt;
    logic       fetch_force;
    logic       if_gnt;
    logic       dm_gnt;
    logic       dm_is_read;

`ifdef MEM_ARB_FAIR_EN
    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .if_req      (bus.if_req),
        .if_gnt      (if_gnt),
        .fetch_force (fetch_force)
    );
`else
    logic fair_unused;
    assign fetch_force = 1'b0;
    assign fair_unused = (STARVE_MAX != 0);
`endif

    assign dm_is_read = (bus.dm_we == {NB{1'b0}});

    // Grant decision: data port wins unless fetch has been starved; nothing granted in reset.
    always_comb begin
        dm_gnt = 1'b0;
        if_gnt = 1'b0;
        if (!rst) begin
            dm_gnt = bus.dm_req && !fetch_force;
            if_gnt = bus.if_req && (!bus.dm_req || fetch_force);
        end
    end

    // Drive the SRAM from whichever port holds the grant; idle drives all zero.
    always_comb begin
        bus.sram_ce    = 1'b0;
        bus.sram_we    = {NB{1'b0}};
        bus.sram_addr  = {ADDR_W{1'b0}};
        bus.sram_wdata = {DATA_W{1'b0}};
        if (dm_gnt) begin
            bus.sram_ce    = 1'b1;
            bus.sram_we    = bus.dm_we;
            bus.sram_addr  = bus.dm_addr;
            bus.sram_wdata = bus.dm_wdata;
        end else if (if_gnt) begin
            bus.sram_ce    = 1'b1;
            bus.sram_addr  = bus.if_addr;
        end
    end

    // Grants and stall indication back to the core.
    always_comb begin
        bus.if_gnt = if_gnt;
        bus.dm_gnt = dm_gnt;
        bus.busy   = (bus.if_req && !if_gnt) || (bus.dm_req && !dm_gnt);
        if (rst) begin
            bus.busy = 1'b0;
        end
    end

    // Response owner register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q <= RSP_NONE;
        end else begin
            rsp_q <= rsp_nxt;
        end
    end

    // Next owner: the read issued this cycle, if any.
    always_comb begin
        rsp_nxt = RSP_NONE;
        if (dm_gnt && dm_is_read) begin
            rsp_nxt = RSP_DM;
        end else if (if_gnt) begin
            rsp_nxt = RSP_IF;
        end
    end

    // Route read data to its owner; suppressed while reset is asserted.
    always_comb begin
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = {DATA_W{1'b0}};
        bus.dm_rvalid = 1'b0;
        bus.dm_rdata  = {DATA_W{1'b0}};
        if (!rst) begin
            case (rsp_q)
                RSP_IF: begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = bus.sram_rdata;
                end
                RSP_DM: begin
                    bus.dm_rvalid = 1'b1;
                    bus.dm_rdata  = bus.sram_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a behavioural byte-lane SRAM.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<(AW-2))-1];

    function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] we);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) if (we[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    always @(posedge clk) begin
        if (bus.sram_ce) begin
            if (bus.sram_we != '0)
                mem[bus.sram_addr[AW-1:2]] <= (mem[bus.sram_addr[AW-1:2]] & ~lane_mask(bus.sram_we))
                                            | (bus.sram_wdata & lane_mask(bus.sram_we));
            else
                bus.sram_rdata <= mem[bus.sram_addr[AW-1:2]];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = '0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
    endtask

    task automatic drive_dm(input logic [NB-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.dm_req   = 1'b1;
        bus.dm_we    = we;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
    endtask

    task automatic drive_if(input logic [AW-1:0] a);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
    endtask

    task automatic preload();
        next_cycle(); idle_inputs(); drive_dm(4'hF, 16'h0010, 32'h0000_0093);
        next_cycle(); drive_dm(4'hF, 16'h0080, 32'h1122_3344);
        next_cycle(); drive_dm(4'hF, 16'h0100, 32'hCAFE_F00D);
        next_cycle(); drive_dm(4'hF, 16'h0200, 32'h0BAD_F00D);
        next_cycle(); idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        drive_if(16'h0010);
        drive_dm(4'hF, 16'h0040, 32'h1234_5678);
        next_cycle(); settle();
        n_checks++; if (bus.if_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_if_gnt got=%0h exp=0", bus.if_gnt); end
        n_checks++; if (bus.dm_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_dm_gnt got=%0h exp=0", bus.dm_gnt); end
        n_checks++; if (bus.sram_ce !== 1'b0 || bus.sram_we !== '0) begin n_fail++; $display("FAIL rst_sram got ce=%0h we=%0h exp 0/0", bus.sram_ce, bus.sram_we); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
        n_checks++; if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got if=%0h dm=%0h exp 0/0", bus.if_rvalid, bus.dm_rvalid); end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        settle();
        n_checks++; if (bus.sram_ce !== 1'b0 || bus.sram_addr !== '0 || bus.sram_wdata !== '0) begin n_fail++; $display("FAIL idle_sram got ce=%0h addr=%0h wdata=%0h exp 0", bus.sram_ce, bus.sram_addr, bus.sram_wdata); end
    endtask

    task automatic test_fetch();
        next_cycle(); idle_inputs(); drive_if(16'h0010); settle();
        n_checks++; if (bus.if_gnt !== 1'b1 || bus.dm_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt got if=%0h dm=%0h exp 1/0", bus.if_gnt, bus.dm_gnt); end
        n_checks++; if (bus.sram_ce !== 1'b1 || bus.sram_addr !== 16'h0010 || bus.sram_we !== '0) begin n_fail++; $display("FAIL fetch_sram got ce=%0h addr=%0h we=%0h exp 1/0010/0", bus.sram_ce, bus.sram_addr, bus.sram_we); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fetch_busy got=%0h exp=0", bus.busy); end
        next_cycle(); idle_inputs(); settle();
        n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0000_0093) begin n_fail++; $display("FAIL fetch_rdata got v=%0h d=%0h exp 1/00000093", bus.if_rvalid, bus.if_rdata); end
        n_checks++; if (bus.dm_rvalid !== 1'b0 || bus.dm_rdata !== '0) begin n_fail++; $display("FAIL fetch_dm_quiet got v=%0h d=%0h exp 0/0", bus.dm_rvalid, bus.dm_rdata); end
    endtask

    task automatic test_dm_write_read();
        next_cycle(); idle_inputs(); drive_dm(4'hF, 16'h0040, 32'hDEAD_BEEF); settle();
        n_checks++; if (bus.dm_gnt !== 1'b1 || bus.sram_we !== 4'hF || bus.sram_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_issue got gnt=%0h we=%0h wd=%0h exp 1/f/deadbeef", bus.dm_gnt, bus.sram_we, bus.sram_wdata); end
        next_cycle(); drive_dm(4'h0, 16'h0040, 32'h0); settle();
        n_checks++; if (bus.dm_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid got dm=%0h if=%0h exp 0/0", bus.dm_rvalid, bus.if_rvalid); end
        next_cycle(); idle_inputs(); settle();
        n_checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL raw_rdata got v=%0h d=%0h exp 1/deadbeef", bus.dm_rvalid, bus.dm_rdata); end
    endtask

    task automatic test_contention();
        next_cycle(); idle_inputs(); drive_if(16'h0010); drive_dm(4'h0, 16'h0040, 32'h0); settle();
        n_checks++; if (bus.dm_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin n_fail++; $display("FAIL cont_gnt got dm=%0h if=%0h exp 1/0", bus.dm_gnt, bus.if_gnt); end
        n_checks++; if (bus.busy !== 1'b1 || bus.sram_addr !== 16'h0040) begin n_fail++; $display("FAIL cont_busy got busy=%0h addr=%0h exp 1/0040", bus.busy, bus.sram_addr); end
        next_cycle(); bus.dm_req = 1'b0; settle();
        n_checks++; if (bus.if_gnt !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL cont_if_gnt got gnt=%0h busy=%0h exp 1/0", bus.if_gnt, bus.busy); end
        n_checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hDEAD_BEEF || bus.if_rvalid !== 1'b0) begin n_fail++; $display("FAIL cont_dm_first got v=%0h d=%0h ifv=%0h exp 1/deadbeef/0", bus.dm_rvalid, bus.dm_rdata, bus.if_rvalid); end
        next_cycle(); idle_inputs(); settle();
        n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0000_0093 || bus.dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL cont_if_second got v=%0h d=%0h dmv=%0h exp 1/00000093/0", bus.if_rvalid, bus.if_rdata, bus.dm_rvalid); end
    endtask

    task automatic test_starve();
        int  gnt_count;
        logic exp_gnt;
        logic fair;
`ifdef MEM_ARB_FAIR_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        gnt_count = 0;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            idle_inputs();
            drive_dm(4'h0, 16'h0040, 32'h0);
            if (!fair || c <= 5) drive_if(16'h0010);
            exp_gnt = fair && (c == 5);
            settle();
            if (bus.if_gnt === 1'b1) gnt_count++;
            n_checks++; if (bus.if_gnt !== exp_gnt || bus.dm_gnt !== !exp_gnt) begin n_fail++; $display("FAIL starve_cycle%0d got if=%0h dm=%0h exp if=%0h", c, bus.if_gnt, bus.dm_gnt, exp_gnt); end
        end
        n_checks++; if (gnt_count != (fair ? 1 : 0)) begin n_fail++; $display("FAIL starve_total got=%0d exp=%0d", gnt_count, fair ? 1 : 0); end
        next_cycle(); idle_inputs();
    endtask

    task automatic test_byte_write();
        next_cycle(); idle_inputs(); drive_dm(4'b0010, 16'h0080, 32'h0000_AB00); settle();
        n_checks++; if (bus.sram_we !== 4'b0010) begin n_fail++; $display("FAIL byte_we got=%0h exp=2", bus.sram_we); end
        next_cycle(); drive_dm(4'h0, 16'h0080, 32'h0);
        next_cycle(); idle_inputs(); settle();
        n_checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'h1122_AB44) begin n_fail++; $display("FAIL byte_merge got v=%0h d=%0h exp 1/1122ab44", bus.dm_rvalid, bus.dm_rdata); end
    endtask

    task automatic test_back_to_back();
        next_cycle(); idle_inputs(); drive_if(16'h0010);
        next_cycle(); drive_if(16'h0200); settle();
        n_checks++; if (bus.if_gnt !== 1'b1 || bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0000_0093) begin n_fail++; $display("FAIL b2b_1 got gnt=%0h v=%0h d=%0h exp 1/1/00000093", bus.if_gnt, bus.if_rvalid, bus.if_rdata); end
        next_cycle(); idle_inputs(); drive_dm(4'h0, 16'h0040, 32'h0); settle();
        n_checks++; if (bus.dm_gnt !== 1'b1 || bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_2 got gnt=%0h v=%0h d=%0h exp 1/1/0badf00d", bus.dm_gnt, bus.if_rvalid, bus.if_rdata); end
        next_cycle(); idle_inputs(); settle();
        n_checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hDEAD_BEEF || bus.if_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_3 got v=%0h d=%0h ifv=%0h exp 1/deadbeef/0", bus.dm_rvalid, bus.dm_rdata, bus.if_rvalid); end
    endtask

    task automatic test_reset_mid();
        next_cycle(); idle_inputs(); drive_if(16'h0010);
        next_cycle(); rst = 1'b1; drive_dm(4'hF, 16'h0100, 32'h5555_5555); settle();
        n_checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== '0) begin n_fail++; $display("FAIL rstmid_rvalid got v=%0h d=%0h exp 0/0", bus.if_rvalid, bus.if_rdata); end
        n_checks++; if (bus.if_gnt !== 1'b0 || bus.dm_gnt !== 1'b0 || bus.sram_ce !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_outs got ifg=%0h dmg=%0h ce=%0h busy=%0h exp 0", bus.if_gnt, bus.dm_gnt, bus.sram_ce, bus.busy); end
        next_cycle(); rst = 1'b0; idle_inputs(); settle();
        n_checks++; if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_owner got if=%0h dm=%0h exp 0/0", bus.if_rvalid, bus.dm_rvalid); end
        next_cycle(); drive_if(16'h0100); settle();
        n_checks++; if (bus.if_gnt !== 1'b1) begin n_fail++; $display("FAIL post_rst_gnt got=%0h exp=1", bus.if_gnt); end
        next_cycle(); idle_inputs(); settle();
        n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL post_rst_rdata got v=%0h d=%0h exp 1/cafef00d", bus.if_rvalid, bus.if_rdata); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        preload();
        test_fetch();
        test_dm_write_read();
        test_contention();
        test_starve();
        test_byte_write();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
